// File: rtl/seq_codec_pkg.sv
// ----------------------------------------------------------------------------
// seq_codec_pkg
// Shared constants for the sequential encoder/decoder pair.
//   SEQ_W   : default number of recovered bits per output word
//   R_RST   : reset value of the decoder's copy of the previous q1 sample
//   PH_RST  : reset value of the decoder's delayed phase replica
//   cnt_w() : width of the bit counter for a W-bit word
// ----------------------------------------------------------------------------
package seq_codec_pkg;

    localparam int   SEQ_W  = 8;
    localparam logic R_RST  = 1'b0;
    localparam logic PH_RST = 1'b1;

    // A width of zero is illegal, so a degenerate W still gets one counter bit.
    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_decoder_if.sv
// ----------------------------------------------------------------------------
// seq_decoder_if
// Valid/ready word stream carrying recovered words out of the decoder.
//   m_data  : recovered word, bit 0 is the earliest recovered bit
//   m_valid : m_data holds an unconsumed word
//   m_ready : consumer takes the word on an edge where m_valid & m_ready
// Modports: master (decoder side), slave (consumer side).
// ----------------------------------------------------------------------------
interface seq_decoder_if #(
    parameter int W = seq_codec_pkg::SEQ_W
);

    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/seq_deser.sv
// ----------------------------------------------------------------------------
// seq_deser
// Packs a stream of recovered bits LSB-first into W-bit words and hands each
// completed word to a one-deep output register on a valid/ready port.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of assembly, output valid and overflow
//   bit_in     : recovered bit
//   bit_vld    : bit_in is to be accepted on this edge
//   overflow   : sticky, a completed word was dropped (output still full)
//   m          : word output stream (master)
// ----------------------------------------------------------------------------
module seq_deser
    import seq_codec_pkg::*;
#(
    parameter int W = SEQ_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          bit_in,
    input  logic          bit_vld,
    output logic          overflow,
    seq_decoder_if.master m
);

    localparam int            CW   = cnt_w(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [W-1:0]  asm_q;
    logic [CW-1:0] bit_cnt;
    logic [W-1:0]  word_next;
    logic          word_done;
    logic          can_load;

    // The last bit of a word never lands in asm_q; it is merged here so the
    // completed word can load into the output register on the same edge.
    always_comb begin
        word_next        = asm_q;
        word_next[W-1]   = bit_in;
    end

    assign word_done = bit_vld && (bit_cnt == LAST);
    // The output register is free if empty or being drained on this edge.
    assign can_load  = !m.m_valid || m.m_ready;

    // Assembly register and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q   <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            asm_q   <= '0;
            bit_cnt <= '0;
        end else if (bit_vld) begin
            if (word_done) begin
                asm_q   <= '0;
                bit_cnt <= '0;
            end else begin
                asm_q[bit_cnt] <= bit_in;
                bit_cnt        <= bit_cnt + 1'b1;
            end
        end
    end

    // One-deep output register; a word arriving while the register is full
    // and not draining is dropped and flagged. m_data is left alone by clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m.m_data  <= '0;
            m.m_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (clr) begin
            m.m_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (word_done) begin
            if (can_load) begin
                m.m_data  <= word_next;
                m.m_valid <= 1'b1;
            end else begin
                overflow  <= 1'b1;
            end
        end else if (m.m_valid && m.m_ready) begin
            m.m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_decoder.sv
// ----------------------------------------------------------------------------
// seq_decoder
// Receive-side decoder for the two-flop sequential encoder
// (q0 toggles, q1 <= A ^ q0 ^ q1, Y = q0 & q1). Runs in lockstep with the
// encoder from a common reset, rebuilds A from the q1 line, checks Y against
// a local replica and emits recovered bits as W-bit words.
// Ports:
//   clk, rst_n : clock shared with the encoder, asynchronous active-low reset
//   q1_in      : encoder q1 register output
//   y_in       : encoder Y output
//   clr        : synchronous clear of word assembly and sticky flags
//                (line lock is kept)
//   overflow   : sticky, a completed word was dropped
//   y_err      : sticky, y_in disagreed with the replica
//   m          : recovered word stream (master)
// ----------------------------------------------------------------------------
module seq_decoder
    import seq_codec_pkg::*;
#(
    parameter int W = SEQ_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          q1_in,
    input  logic          y_in,
    input  logic          clr,
    output logic          overflow,
    output logic          y_err,
    seq_decoder_if.master m
);

    // r_q holds the q1 value before the encoder's last update and ph_q the q0
    // that the encoder used in that update, so q1_in ^ r_q ^ ph_q undoes it.
    logic r_q;
    logic ph_q;
    logic prime_q;
    logic b;
    logic y_exp;
    logic bit_vld;

    assign b       = q1_in ^ r_q ^ ph_q;
    // The encoder's current q0 is the inverse of the delayed replica.
    assign y_exp   = ~ph_q & q1_in;
    // The first edge after reset sees only reset state on the line, and the
    // bit under a clr edge belongs to the word being discarded.
    assign bit_vld = ~prime_q & ~clr;

    // Line state; untouched by clr so lock survives a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= R_RST;
            ph_q    <= PH_RST;
            prime_q <= 1'b1;
        end else begin
            r_q     <= q1_in;
            ph_q    <= ~ph_q;
            prime_q <= 1'b0;
        end
    end

    // Y checker, active from the priming edge on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_err <= 1'b0;
        end else if (clr) begin
            y_err <= 1'b0;
        end else if (y_in != y_exp) begin
            y_err <= 1'b1;
        end
    end

    seq_deser #(
        .W (W)
    ) u_deser (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .bit_in   (b),
        .bit_vld  (bit_vld),
        .overflow (overflow),
        .m        (m)
    );

endmodule
